legv8_control_unit: RTL

//  Multi-cycle control FSM sitting directly upstream of the LEGv8 datapath. Consumes IR_out and
//  the registered 4-bit status; each cycle it produces the 36-bit control word and 32-bit

---
 rtl/legv8_control_unit.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/legv8_control_unit.sv
// LEGv8 multi-cycle control unit: FETCH -> DECODE -> EXEC [-> MEM], sticky HALT on illegal opcode.
// State is registered; controlWord and k are decoded from state, IR and status, forced to zero during reset.
module legv8_control_unit #(
  parameter int CW_WIDTH        = 36,
  parameter int K_WIDTH         = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         IR,
  input  logic [3:0]          status,
  output logic [CW_WIDTH-1:0] controlWord,
  output logic [K_WIDTH-1:0]  k,
  output logic [2:0]          state,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS,
    OP_ADDI, OP_SUBI, OP_LDUR, OP_STUR,
    OP_B, OP_BL, OP_BR, OP_BCOND, OP_CBZ, OP_CBNZ, OP_ILL
  } op_t;

  typedef struct packed {
    logic [4:0] fs;
    logic [4:0] sa;
    logic [4:0] sb;
    logic [4:0] da;
    logic       w_reg;
    logic       c0;
    logic [1:0] mem_cs;
    logic       b_sel;
    logic       mem_write_en;
    logic       ir_load;
    logic       status_load;
    logic [1:0] size;
    logic       add_tri_sel;
    logic [1:0] data_tri_sel;
    logic       pc_sel;
    logic [1:0] pc_fs;
  } cw_t;

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01010;

  state_t      r_state;
  logic        r_sub;
  logic        r_halted;
  op_t         w_op;
  cw_t         w_cw;
  logic [31:0] w_k;
  logic [35:0] w_cw_bits;
  logic        w_is_cb;
  logic [31:0] w_imm9;
  logic [31:0] w_imm19;
  logic [31:0] w_imm26;

  // Status is packed {V,C,N,Z}; condition codes follow the LEGv8 encoding.
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] st);
    logic v, c, n, z;
    {v, c, n, z} = st;
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c && !z;
      4'h9:    return !(c && !z);
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  // Longest opcode wins: 11-bit, then 10-, 8-, 6-bit prefixes.
  always_comb begin
    w_op = OP_ILL;
    if      (IR[31:21] == 11'b10001011000) w_op = OP_ADD;
    else if (IR[31:21] == 11'b11001011000) w_op = OP_SUB;
    else if (IR[31:21] == 11'b10001010000) w_op = OP_AND;
    else if (IR[31:21] == 11'b10101010000) w_op = OP_ORR;
    else if (IR[31:21] == 11'b10101011000) w_op = OP_ADDS;
    else if (IR[31:21] == 11'b11101011000) w_op = OP_SUBS;
    else if (IR[31:21] == 11'b11111000010) w_op = OP_LDUR;
    else if (IR[31:21] == 11'b11111000000) w_op = OP_STUR;
    else if (IR[31:21] == 11'b11010110000) w_op = OP_BR;
    else if (IR[31:22] == 10'b1001000100)  w_op = OP_ADDI;
    else if (IR[31:22] == 10'b1101000100)  w_op = OP_SUBI;
    else if (IR[31:24] == 8'b01010100)     w_op = OP_BCOND;
    else if (IR[31:24] == 8'b10110100)     w_op = OP_CBZ;
    else if (IR[31:24] == 8'b10110101)     w_op = OP_CBNZ;
    else if (IR[31:26] == 6'b000101)       w_op = OP_B;
    else if (IR[31:26] == 6'b100101)       w_op = OP_BL;
  end

  assign w_is_cb = (w_op == OP_CBZ) || (w_op == OP_CBNZ);
  assign w_imm9  = {{23{IR[20]}}, IR[20:12]};
  assign w_imm19 = {{13{IR[23]}}, IR[23:5]};
  assign w_imm26 = {{6{IR[25]}}, IR[25:0]};

  always_comb begin
    w_cw = '0;
    w_k  = '0;
    case (r_state)
      S_FETCH: begin
        w_cw.add_tri_sel  = 1'b1;
        w_cw.data_tri_sel = 2'b11;
        w_cw.mem_cs       = 2'b01;
        w_cw.size         = 2'b11;
        w_cw.ir_load      = 1'b1;
        w_cw.pc_fs        = 2'b01;
      end
      S_EXEC, S_MEM: begin
        case (w_op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS: begin
            w_cw.sa          = IR[9:5];
            w_cw.sb          = IR[20:16];
            w_cw.da          = IR[4:0];
            w_cw.w_reg       = 1'b1;
            w_cw.status_load = (w_op == OP_ADDS) || (w_op == OP_SUBS);
            w_cw.c0          = (w_op == OP_SUB) || (w_op == OP_SUBS);
            case (w_op)
              OP_AND:          w_cw.fs = FS_AND;
              OP_ORR:          w_cw.fs = FS_ORR;
              OP_SUB, OP_SUBS: w_cw.fs = FS_SUB;
              default:         w_cw.fs = FS_ADD;
            endcase
          end
          OP_ADDI, OP_SUBI: begin
            w_cw.fs    = (w_op == OP_SUBI) ? FS_SUB : FS_ADD;
            w_cw.c0    = (w_op == OP_SUBI);
            w_cw.sa    = IR[9:5];
            w_cw.da    = IR[4:0];
            w_cw.b_sel = 1'b1;
            w_cw.w_reg = 1'b1;
            w_k        = {20'd0, IR[21:10]};
          end
          OP_LDUR: begin
            w_cw.fs     = FS_ADD;
            w_cw.sa     = IR[9:5];
            w_cw.b_sel  = 1'b1;
            w_cw.mem_cs = 2'b10;
            w_cw.size   = 2'b11;
            w_k         = w_imm9;
            // The load result is written back only in the MEM cycle.
            if (r_state == S_MEM) begin
              w_cw.data_tri_sel = 2'b11;
              w_cw.da           = IR[4:0];
              w_cw.w_reg        = 1'b1;
            end
          end
          OP_STUR: begin
            w_cw.fs           = FS_ADD;
            w_cw.sa           = IR[9:5];
            w_cw.sb           = IR[4:0];
            w_cw.b_sel        = 1'b1;
            w_cw.mem_cs       = 2'b10;
            w_cw.size         = 2'b11;
            w_cw.data_tri_sel = 2'b01;
            w_cw.mem_write_en = 1'b1;
            w_k               = w_imm9;
          end
          OP_B, OP_BL: begin
            w_cw.pc_sel = 1'b1;
            w_cw.pc_fs  = 2'b10;
            w_k         = w_imm26;
            if (w_op == OP_BL) begin
              w_cw.data_tri_sel = 2'b10;
              w_cw.da           = 5'd30;
              w_cw.w_reg        = 1'b1;
            end
          end
          OP_BR: begin
            w_cw.sa    = IR[9:5];
            w_cw.pc_fs = 2'b11;
          end
          OP_BCOND: begin
            w_cw.pc_sel = 1'b1;
            w_cw.pc_fs  = cond_true(IR[3:0], status) ? 2'b10 : 2'b00;
            w_k         = w_imm19;
          end
          OP_CBZ, OP_CBNZ: begin
            if (!r_sub) begin
              // Pass Rt through the ALU (Rt | 0) purely to refresh the Z flag.
              w_cw.fs          = FS_ORR;
              w_cw.sa          = IR[4:0];
              w_cw.b_sel       = 1'b1;
              w_cw.status_load = 1'b1;
            end else begin
              w_cw.pc_sel = 1'b1;
              w_cw.pc_fs  = (status[0] == (w_op == OP_CBZ)) ? 2'b10 : 2'b00;
              w_k         = w_imm19;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_FETCH;
      r_sub    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_sub <= 1'b0;
          if ((w_op == OP_ILL) && HALT_ON_ILLEGAL) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_is_cb && !r_sub) begin
            r_sub <= 1'b1;
          end else begin
            r_sub   <= 1'b0;
            r_state <= (w_op == OP_LDUR) ? S_MEM : S_FETCH;
          end
        end
        S_MEM:   r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign w_cw_bits   = w_cw;
  assign controlWord = reset ? '0 : CW_WIDTH'(w_cw_bits);
  assign k           = reset ? '0 : K_WIDTH'(w_k);
  assign state       = r_state;
  assign halted      = r_halted;

endmodule
